icache: RTL

Direct-mapped instruction cache between the IF stage and the memory controller's IF port. It takes a word fetch request from IF and returns a 32-bit instruction. Hits are served from on-chip arrays. Misses are refilled by four byte-serial reads through the memory controller, assembled little-endian. While it is working it raises a stall request so IF and pc_reg hold.

---
 rtl/icache_if.sv | 16 +
 rtl/icache.sv | 91 +++++++++
 2 files changed

// File: rtl/icache_if.sv
// icache_if: fetch-side (rdy, flush, if_req/if_addr -> inst_valid/inst/busy) and memctrl-side (mem_req/mem_addr <- mem_rvalid/mem_rdata) signals of the icache
interface icache_if;
  logic rdy;
  logic flush;
  logic if_req;
  logic [31:0] if_addr;
  logic inst_valid;
  logic [31:0] inst;
  logic busy;
  logic mem_req;
  logic [31:0] mem_addr;
  logic mem_rvalid;
  logic [7:0] mem_rdata;
  modport slave(input rdy, flush, if_req, if_addr, mem_rvalid, mem_rdata, output inst_valid, inst, busy, mem_req, mem_addr);
  modport master(output rdy, flush, if_req, if_addr, mem_rvalid, mem_rdata, input inst_valid, inst, busy, mem_req, mem_addr);
endinterface

// File: rtl/icache.sv
// icache: direct-mapped one-word-line instruction cache; clk, async active-high rst, bus (icache_if.slave) carries IF fetch and byte-serial memctrl refill
module icache #(
  parameter int INDEX_W = 7,
  parameter int ADDR_W = 18
) (
  input logic clk,
  input logic rst,
  icache_if.slave bus
);
  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int LINES = 1 << INDEX_W;
  typedef enum logic [1:0] {IDLE, LOOKUP, FILL} state_t;
  state_t r_state, w_next;
  logic [31:0] r_addr, r_inst, r_mem_addr;
  logic r_inst_valid, r_mem_req;
  logic [1:0] r_cnt;
  logic [7:0] r_buf [4];
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];
  logic [31:0] r_data [LINES];
  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic w_io, w_hit, w_last, w_fill, w_byte;
  assign w_idx = r_addr[INDEX_W+1:2];
  assign w_tag = r_addr[ADDR_W-1:INDEX_W+2];
  assign w_io = r_addr[17:16] == 2'b11;
  assign w_hit = r_valid[w_idx] && r_tag[w_idx] == w_tag && !w_io;
  assign w_byte = bus.rdy && !bus.flush && r_state == FILL && bus.mem_rvalid;
  assign w_last = r_state == FILL && bus.mem_rvalid && r_cnt == 2'd3;
  assign w_fill = w_byte && r_cnt == 2'd3 && !w_io;
  assign bus.inst_valid = r_inst_valid;
  assign bus.inst = r_inst;
  assign bus.busy = r_state != IDLE;
  assign bus.mem_req = r_mem_req;
  assign bus.mem_addr = r_mem_addr;
  always_comb begin
    w_next = r_state;
    if (bus.flush) w_next = IDLE;
    else if (r_state == IDLE && bus.if_req) w_next = LOOKUP;
    else if (r_state == LOOKUP) w_next = w_hit ? IDLE : FILL;
    else if (w_last) w_next = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_inst_valid <= 1'b0;
      r_inst <= '0;
      r_mem_req <= 1'b0;
      r_mem_addr <= '0;
      r_cnt <= '0;
      r_addr <= '0;
    end else if (bus.rdy) begin
      r_state <= w_next;
      r_inst_valid <= 1'b0;
      if (w_fill) r_valid[w_idx] <= 1'b1;
      if (bus.flush) r_mem_req <= 1'b0;
      else case (r_state)
        IDLE: if (bus.if_req) r_addr <= {bus.if_addr[31:2], 2'b00};
        LOOKUP: begin
          if (w_hit) begin
            r_inst <= r_data[w_idx];
            r_inst_valid <= 1'b1;
          end else begin
            r_cnt <= '0;
            r_mem_req <= 1'b1;
            r_mem_addr <= r_addr;
          end
        end
        FILL: begin
          if (bus.mem_rvalid) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_inst <= {bus.mem_rdata, r_buf[2], r_buf[1], r_buf[0]};
              r_inst_valid <= 1'b1;
              r_mem_req <= 1'b0;
            end else r_mem_addr <= r_addr + {30'd0, r_cnt + 2'd1};
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (w_byte) r_buf[r_cnt] <= bus.mem_rdata;
    if (w_fill) begin
      r_data[w_idx] <= {bus.mem_rdata, r_buf[2], r_buf[1], r_buf[0]};
      r_tag[w_idx] <= w_tag;
    end
  end
endmodule
